// File: rtl/serial_mpy_param.sv
// -----------------------------------------------------------------------------
// serial_mpy_param
//   Sequential shift-add multiplier. It handles one multiplier bit per clock,
//   LSB first, on the operand magnitudes. The sign is applied once at the end.
//   The product is exact and 2*WIDTH bits wide. Latency is WIDTH+1 cycles from
//   the accepting edge. Only one product is in flight at a time.
//
// Ports
//   CLK        rising-edge clock
//   reset_n    asynchronous active-low reset
//   start      request; accepted only while busy=0
//   tc         1 = signed two's complement operands, 0 = unsigned (with start)
//   in_a       multiplicand (sampled with start)
//   in_b       multiplier   (sampled with start)
//   out        2*WIDTH-bit product; changes only at completion or reset
//   out_valid  high from completion until the next accepted start
//   busy       high while a multiply is in progress (RUN or FIX)
// -----------------------------------------------------------------------------
module serial_mpy_param #(
   parameter int WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 tc,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic [2*WIDTH-1:0]   out,
   output logic                 out_valid,
   output logic                 busy
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state, state_nx;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic               neg;
   logic [CW-1:0]      cnt;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     sum;

   // The most negative operand becomes 2^(WIDTH-1). That value still fits in
   // WIDTH unsigned bits, so taking the magnitude cannot overflow.
   assign a_mag = (tc && in_a[WIDTH-1]) ? -in_a : in_a;
   assign b_mag = (tc && in_b[WIDTH-1]) ? -in_b : in_b;

   // Add into the upper half and keep the carry. The carry becomes the new MSB
   // after the right shift below.
   assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);

   assign busy = (state != IDLE);

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (cnt == CW'(1)) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Datapath
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         neg       <= 1'b0;
         cnt       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand     <= a_mag;
                  mplier    <= b_mag;
                  neg       <= tc & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                  acc       <= '0;
                  cnt       <= CW'(WIDTH);
                  out_valid <= 1'b0;
               end
            end
            RUN: begin
               acc    <= {sum, acc[WIDTH-1:1]};
               mplier <= mplier >> 1;
               cnt    <= cnt - CW'(1);
            end
            FIX: begin
               out       <= neg ? -acc : acc;
               out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_mpy_param.sv
module tb_serial_mpy_param;

   logic        CLK = 1'b0;
   logic        reset_n;
   logic        start8, tc8, start16, tc16;
   logic [7:0]  a8, b8;
   logic [15:0] a16, b16;
   logic [15:0] out8;
   logic [31:0] out16;
   logic        vld8, busy8, vld16, busy16;

   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   serial_mpy_param #(.WIDTH(8)) u_mpy8 (
      .CLK(CLK), .reset_n(reset_n), .start(start8), .tc(tc8),
      .in_a(a8), .in_b(b8), .out(out8), .out_valid(vld8), .busy(busy8));

   serial_mpy_param #(.WIDTH(16)) u_mpy16 (
      .CLK(CLK), .reset_n(reset_n), .start(start16), .tc(tc16),
      .in_a(a16), .in_b(b16), .out(out16), .out_valid(vld16), .busy(busy16));

   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: interpret the operands as integers, multiply them,
   // and keep the low 2*w bits.
   function automatic longint model(int w, bit t, longint a, longint b);
      longint sa, sb, mask;
      sa   = a;
      sb   = b;
      mask = (longint'(1) << (2 * w)) - 1;
      if (t) begin
         if (a[w-1]) sa = a - (longint'(1) << w);
         if (b[w-1]) sb = b - (longint'(1) << w);
      end
      return (sa * sb) & mask;
   endfunction

   // One 8-bit multiply. It measures latency and checks the result.
   // With junk set, extra start pulses carrying other operands are driven
   // while the multiply is busy.
   task automatic run8(input bit t, input logic [7:0] a, input logic [7:0] b,
                       input bit junk, input string tag);
      longint exp;
      int     lat;
      exp = model(8, t, a, b);
      lat = 0;
      @(negedge CLK);
      start8 = 1'b1; tc8 = t; a8 = a; b8 = b;
      @(posedge CLK); #1;
      start8 = 1'b0;
      chk({tag, "_busy_acc"}, busy8, 1);
      chk({tag, "_vld_acc"}, vld8, 0);
      for (int i = 1; i <= 14; i++) begin
         if (junk && (i == 3 || i == 5)) begin
            start8 = 1'b1; tc8 = ~t; a8 = 8'($urandom); b8 = 8'($urandom);
         end
         @(posedge CLK); #1;
         start8 = 1'b0;
         if (vld8) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_lat"}, lat, 9);
      chk({tag, "_out"}, out8, exp);
      chk({tag, "_busy_done"}, busy8, 0);
   endtask

   task automatic run16(input bit t, input logic [15:0] a, input logic [15:0] b,
                        input string tag);
      longint exp;
      int     lat;
      exp = model(16, t, a, b);
      lat = 0;
      @(negedge CLK);
      start16 = 1'b1; tc16 = t; a16 = a; b16 = b;
      @(posedge CLK); #1;
      start16 = 1'b0;
      for (int i = 1; i <= 22; i++) begin
         @(posedge CLK); #1;
         if (vld16) begin
            lat = i;
            break;
         end
      end
      chk({tag, "_lat"}, lat, 17);
      chk({tag, "_out"}, out16, exp);
      chk({tag, "_busy"}, busy16, 0);
   endtask

   initial begin
      logic [15:0] held;
      longint      exp;
      bit          t;
      logic [7:0]  ra, rb;

      reset_n = 1'b0;
      start8 = 0; tc8 = 0; a8 = 0; b8 = 0;
      start16 = 0; tc16 = 0; a16 = 0; b16 = 0;
      #1;
      chk("rst_out8", out8, 0);
      chk("rst_vld8", vld8, 0);
      chk("rst_busy8", busy8, 0);
      chk("rst_out16", out16, 0);
      #12 reset_n = 1'b1;

      // Basic signed sequence
      run8(1, 8'(32), 8'(9), 0, "s0");
      run8(1, 8'(100), 8'(0), 0, "s1");
      run8(1, 8'(-101), 8'(14), 0, "s2");
      run8(1, 8'(123), 8'(-7), 0, "s3");
      run8(1, 8'(-1), 8'(-60), 0, "s4");
      chk("s4_lit", out8, 60);

      // Corners
      run8(1, 8'h80, 8'h80, 0, "c_minmin");
      chk("c_minmin_lit", out8, 16384);
      run8(1, 8'h80, 8'h7f, 0, "c_minmax");
      run8(0, 8'hff, 8'hff, 0, "c_umax");
      chk("c_umax_lit", out8, 65025);
      run8(0, 8'h80, 8'h02, 0, "c_u80");
      chk("c_u80_lit", out8, 256);

      // The result must stay put while idle and valid.
      held = out8;
      repeat (5) @(posedge CLK);
      #1;
      chk("hold_out", out8, held);
      chk("hold_vld", vld8, 1);

      // Start pulses while busy are ignored.
      run8(1, 8'(-45), 8'(77), 1, "junk");

      // Random operands in both modes
      for (int k = 0; k < 20; k++)
         run8(1'($urandom), 8'($urandom), 8'($urandom), 0, "rnd");

      // Start held high: one product per WIDTH+2 cycles
      exp = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge CLK);
         t = 1'($urandom); ra = 8'($urandom); rb = 8'($urandom);
         start8 = 1'b1; tc8 = t; a8 = ra; b8 = rb;
         if (k % 10 == 0) exp = model(8, t, ra, rb);
         @(posedge CLK); #1;
         if (k % 10 == 0) begin
            chk("b2b_vld_low", vld8, 0);
            chk("b2b_busy", busy8, 1);
         end
         if (k % 10 == 9) begin
            chk("b2b_out", out8, exp);
            chk("b2b_vld", vld8, 1);
         end
      end
      start8 = 1'b0;
      repeat (12) @(posedge CLK);

      // A mid-operation reset aborts at once.
      run8(0, 8'(200), 8'(3), 0, "pre_rst");
      @(negedge CLK);
      start8 = 1'b1; tc8 = 1; a8 = 8'(55); b8 = 8'(-3);
      @(posedge CLK); #1;
      start8 = 1'b0;
      repeat (4) @(posedge CLK);
      #2 reset_n = 1'b0;
      #1;
      chk("mrst_out", out8, 0);
      chk("mrst_vld", vld8, 0);
      chk("mrst_busy", busy8, 0);
      #3 reset_n = 1'b1;
      run8(1, 8'(7), 8'(6), 0, "post_rst");
      chk("post_rst_lit", out8, 42);

      // 16-bit instance
      run16(1, 16'h8000, 16'h8000, "w16_minmin");
      chk("w16_minmin_lit", out16, 1073741824);
      run16(1, 16'(1234), 16'(-567), "w16_mix");
      for (int k = 0; k < 6; k++)
         run16(1'($urandom), 16'($urandom), 16'($urandom), "w16_rnd");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
